cacheline_adapter: RTL and testbench
====================================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 The block SHALL have no parameters; line width is fixed at 256 bits, burst width at 64 bits, and burst count at 4.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 line_i  input  256  write line from the cache.
REQ-005 line_o  output  256  assembled read line to the cache.
REQ-006 address_i  input  32  cache line address.
REQ-007 read_i  input  1  cache line-read request, held until resp_o.
REQ-008 write_i  input  1  cache line-write request, held until resp_o.
REQ-009 resp_o  output  1  one-cycle completion pulse to the cache.
REQ-010 burst_i  input  64  read data beat from memory.
REQ-011 burst_o  output  64  write data beat to memory.
REQ-012 address_o  output  32  line-aligned memory address.
REQ-013 read_o  output  1  memory read request.
REQ-014 write_o  output  1  memory write request.
REQ-015 resp_i  input  1  memory beat acknowledge; one beat is transferred per cycle in which it is high.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-017 IDLE SHALL transition as follows: read_i=1 -> READ; otherwise write_i=1 -> WRITE; otherwise stay.
- On either transition the block latches address_i.
- On a write it also latches line_i.
- The beat counter is cleared to 0.
REQ-018 If read_i and write_i are both 1 in IDLE, the read SHALL win and the write SHALL be ignored.
REQ-019 address_o SHALL equal {latched_addr[31:5], 5'b0} at all times.
REQ-020 In READ, read_o SHALL be 1.
- On each cycle with resp_i=1, burst_i is stored in line_o[64*k+63:64*k], where k is the counter value.
- The counter then increments.
- When k=3 is stored, the next state is DONE.
REQ-021 In WRITE, write_o SHALL be 1 and burst_o SHALL equal latched_line[64*k+63:64*k].
- resp_i=1 increments k.
- resp_i=1 at k=3 moves the FSM to DONE.
REQ-022 A resp_i=0 cycle in READ or WRITE SHALL stall: no counter change and no data capture.
REQ-023 In DONE, resp_o SHALL be 1 for exactly one cycle, read_o and write_o SHALL be 0, and the next state SHALL be IDLE.
REQ-024 read_o, write_o and resp_o SHALL be 0 in IDLE.
REQ-025 resp_i seen in IDLE or DONE SHALL be ignored.
REQ-026 line_o SHALL hold its last assembled value until the next read captures beat 0.
REQ-027 The requester SHALL deassert read_i/write_i in the cycle after resp_o.
- The adapter samples requests only in IDLE.
- A request still high in IDLE starts a new transaction.
REQ-028 Minimum latency with resp_i tied high SHALL be as follows: request seen in IDLE at edge n; beats at edges n+1..n+4; resp_o high in cycle n+5.
REQ-029 The counter SHALL be 2 bits and SHALL wrap from 3 to 0 only on the DONE transition.
REQ-030 burst_o SHALL be 0 outside WRITE.
REQ-031 address_i, line_i, read_i and write_i changes after acceptance SHALL not affect the in-flight transaction.

Reset
REQ-032 When rst asserts, the block SHALL immediately, without waiting for clk:
- enter IDLE;
- clear the counter, latched address and latched line;
- drive line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
REQ-033 Reset mid-READ or mid-WRITE SHALL abort the transaction with no resp_o, and partial line_o data SHALL be cleared.
REQ-034 After rst deasserts, the first request SHALL be accepted on the first rising edge with the FSM in IDLE.

Verification
REQ-035 Read line: address_i=0x1234_5678, read_i=1, resp_i high 4 cycles with burst_i=0x0..0A, 0x..0B, 0x..0C, 0x..0D -> address_o=0x1234_5660; read_o high 4 cycles; line_o={D,C,B,A}; resp_o pulses once in cycle n+5.
REQ-036 Write line: line_i={64'h4444..,64'h3333..,64'h2222..,64'h1111..}, write_i=1 -> burst_o=1111.., 2222.., 3333.., 4444.. on successive acked cycles; write_o drops in DONE; one resp_o.
REQ-037 Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 captures in order; resp_o the cycle after the 7th pattern cycle; no capture on the 0 cycles.
REQ-038 Simultaneous read_i=write_i=1 -> only read_o asserts; write_o stays 0; one resp_o.
REQ-039 rst pulsed asynchronously after 2 read beats -> read_o=0 and line_o=0 immediately, no resp_o; a following write completes normally with 4 beats.
REQ-040 Back-to-back: read, then write issued the cycle after resp_o -> the write is accepted in IDLE; the earlier line_o is preserved through the write.

Source files
------------

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges 256-bit cache line reads/writes to four 64-bit memory bursts.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   line_i / line_o       write line from cache / assembled read line to cache
//   address_i             cache line address
//   read_i / write_i      cache requests, held until resp_o
//   resp_o                one-cycle completion pulse to the cache
//   burst_i / burst_o     memory read beat / memory write beat
//   address_o             line-aligned memory address
//   read_o / write_o      memory requests
//   resp_i                memory beat acknowledge
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t       state;
    logic [1:0]   k;
    logic [31:0]  addr;
    logic [255:0] line;
    assign address_o = {addr[31:5], 5'b0};
    assign burst_o   = (state == WRITE) ? line[{k, 6'd0} +: 64] : 64'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k       <= 2'd0;
            addr    <= 32'd0;
            line    <= 256'd0;
            line_o  <= 256'd0;
            read_o  <= 1'b0;
            write_o <= 1'b0;
            resp_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    k <= 2'd0;
                    if (read_i) begin
                        state  <= READ;
                        read_o <= 1'b1;
                        addr   <= address_i;
                    end else if (write_i) begin
                        state   <= WRITE;
                        write_o <= 1'b1;
                        addr    <= address_i;
                        line    <= line_i;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[{k, 6'd0} +: 64] <= burst_i;
                        // k wraps 3 -> 0 naturally on the final beat
                        k <= k + 2'd1;
                        if (k == 2'd3) begin
                            state  <= DONE;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        k <= k + 2'd1;
                        if (k == 2'd3) begin
                            state   <= DONE;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    resp_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: randomized and directed transactions against a line-level reference model.
module tb_cacheline_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [63:0]  burst_i, burst_o;

    cacheline_adapter dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk = 0;
    logic [255:0] m_line;
    logic [31:0]  m_addr;
    logic         e_rd, e_wr, e_resp;
    logic [63:0]  e_burst;
    int n_rd = 0, n_wr = 0, n_resp = 0;
    logic [63:0] wq[$];
    bit pat[$];
    logic [63:0] bq[$];

    function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle compare against the model, plus observation counters.
    always @(negedge clk) begin
        if (chk) begin
            check("read_o", read_o, e_rd);
            check("write_o", write_o, e_wr);
            check("resp_o", resp_o, e_resp);
            check("burst_o", burst_o, e_burst);
            check("line_o", line_o, m_line);
            check("address_o", address_o, m_addr & ~32'h1F);
        end
        if (read_o) n_rd++;
        if (write_o) n_wr++;
        if (resp_o) n_resp++;
        if (write_o && resp_i) wq.push_back(burst_o);
    end

    task automatic idle_cycle();
        read_i = 0; write_i = 0; resp_i = 1'($urandom);
        burst_i = {$urandom, $urandom};
        e_rd = 0; e_wr = 0; e_resp = 0; e_burst = 0;
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] l);
        logic [255:0] wl;
        int beats;
        int cyc;
        read_i = rd; write_i = wr; address_i = a; line_i = l;
        resp_i = 1'($urandom); burst_i = {$urandom, $urandom};
        e_rd = 0; e_wr = 0; e_resp = 0; e_burst = 0;
        @(posedge clk); #1;
        m_addr = a;
        wl = l;
        beats = 0;
        cyc = 0;
        while (beats < 4) begin
            if (cyc > 200) begin
                check("txn_timeout", 256'(beats), 256'd4);
                return;
            end
            e_rd = rd; e_wr = !rd; e_resp = 0;
            e_burst = rd ? 64'd0 : wl[64*beats +: 64];
            resp_i = (pat.size() != 0) ? pat.pop_front() : ($urandom_range(3) != 0);
            burst_i = (bq.size() != 0) ? bq.pop_front() : {$urandom, $urandom};
            address_i = $urandom;
            line_i = {8{$urandom}};
            if (rd) write_i = 1'($urandom); else read_i = 1'($urandom);
            @(posedge clk); #1;
            if (resp_i) begin
                if (rd) m_line[64*beats +: 64] = burst_i;
                beats++;
            end
            cyc++;
        end
        e_rd = 0; e_wr = 0; e_resp = 1; e_burst = 0;
        resp_i = 1'($urandom);
        @(posedge clk); #1;
        e_resp = 0; read_i = 0; write_i = 0;
    endtask

    initial begin
        int b_rd, b_wr, b_resp, b_wq;
        logic [255:0] rdline;
        rst = 1; read_i = 0; write_i = 0; resp_i = 0;
        line_i = '0; address_i = '0; burst_i = '0;
        e_rd = 0; e_wr = 0; e_resp = 0; e_burst = 0;
        #1;
        check("reset_line_o", line_o, 256'd0);
        check("reset_address_o", address_o, 32'd0);
        check("reset_reqs", {read_o, write_o, resp_o}, 3'b000);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        m_line = '0; m_addr = '0;
        chk = 1;
        idle_cycle();

        // Directed read line
        b_rd = n_rd; b_resp = n_resp;
        pat = '{1, 1, 1, 1};
        bq = '{64'h0A, 64'h0B, 64'h0C, 64'h0D};
        run_txn(1, 0, 32'h1234_5678, '0);
        check("read_address_o", address_o, 32'h1234_5660);
        check("read_line", line_o, {64'h0D, 64'h0C, 64'h0B, 64'h0A});
        check("read_rd_cycles", 256'(n_rd - b_rd), 256'd4);
        check("read_resp_count", 256'(n_resp - b_resp), 256'd1);
        rdline = line_o;

        // Back-to-back write, directed line
        b_wr = n_wr; b_resp = n_resp; b_wq = wq.size();
        run_txn(0, 1, 32'h0000_0040,
                {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});
        check("write_wr_cycles_min", 256'(n_wr - b_wr >= 4), 256'd1);
        check("write_resp_count", 256'(n_resp - b_resp), 256'd1);
        check("write_beat0", wq[b_wq], 64'h1111111111111111);
        check("write_beat1", wq[b_wq+1], 64'h2222222222222222);
        check("write_beat2", wq[b_wq+2], 64'h3333333333333333);
        check("write_beat3", wq[b_wq+3], 64'h4444444444444444);
        check("line_o_preserved", line_o, rdline);
        idle_cycle();

        // Stalled read
        b_rd = n_rd; b_resp = n_resp;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        bq = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h17};
        run_txn(1, 0, 32'hCAFE_0000, '0);
        check("stall_line", line_o, {64'h17, 64'h15, 64'h14, 64'h11});
        check("stall_rd_cycles", 256'(n_rd - b_rd), 256'd7);
        check("stall_resp_count", 256'(n_resp - b_resp), 256'd1);

        // Simultaneous read and write: read wins
        b_wr = n_wr; b_resp = n_resp;
        run_txn(1, 1, 32'h0BAD_F00D, {8{32'hDEAD_BEEF}});
        check("both_write_o", 256'(n_wr - b_wr), 256'd0);
        check("both_resp_count", 256'(n_resp - b_resp), 256'd1);

        // Asynchronous reset after two read beats
        chk = 0;
        b_resp = n_resp;
        read_i = 1; address_i = 32'hABCD_EF12; resp_i = 1; burst_i = 64'h5555;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        check("pre_rst_read_o", read_o, 1'b1);
        rst = 1;
        #1;
        check("rst_read_o", read_o, 1'b0);
        check("rst_line_o", line_o, 256'd0);
        check("rst_address_o", address_o, 32'd0);
        check("rst_resp_o", resp_o, 1'b0);
        read_i = 0; resp_i = 0;
        @(posedge clk); #1;
        rst = 0;
        m_line = '0; m_addr = '0;
        check("rst_no_resp", 256'(n_resp - b_resp), 256'd0);
        chk = 1;
        b_resp = n_resp; b_wq = wq.size();
        run_txn(0, 1, 32'h0000_1000, {64'hD, 64'hC, 64'hB, 64'hA});
        check("post_rst_write_beats", 256'(wq.size() - b_wq), 256'd4);
        check("post_rst_write_resp", 256'(n_resp - b_resp), 256'd1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int g;
            bit rd, wr;
            g = $urandom_range(2);
            for (int j = 0; j < g; j++) idle_cycle();
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            run_txn(rd, wr, $urandom, {8{$urandom}});
        end
        idle_cycle();
        chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
